score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Sequencing controller for the on-screen score digits. It owns the 3-digit BCD score register that feeds the low, mid and high digit drawers.
- Round-robin arbitration among three score-event requesters; the granted event's point value is added digit-by-digit with a multi-cycle carry FSM.
- Saturates at 999, clears on new game, and drives a frame-counted flash enable for the scoreboard after every change.

Parameters:
- VALUE0, 4'd1, points added for requester 0 (BCD, 0..9)
- VALUE1, 4'd5, points added for requester 1 (BCD, 0..9)
- VALUE2, 4'd9, points added for requester 2 (BCD, 0..9)
- FLASH_FRAMES, 8'd30, frames scoreFlash stays high after a change

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per VGA frame
- newGame  in  1  synchronous clear of score; level or pulse
- scoreReq  in  3  per-requester request, level; held until that requester's grant bit is seen
- scoreGrant  out  3  one-hot acknowledge, high for exactly one cycle
- lowDigit  out  4  BCD units digit
- midDigit  out  4  BCD tens digit
- highDigit  out  4  BCD hundreds digit
- busy  out  1  FSM not in IDLE
- scoreChanged  out  1  one-cycle pulse after a committed change
- saturated  out  1  score has reached 999
- scoreFlash  out  1  high while the flash counter is non-zero

Behaviour:
- Reset (sampled at posedge clk while reset=1): all digits 0, state IDLE, scoreGrant 0, scoreChanged 0, saturated 0, flash counter 0, round-robin pointer at requester 0.
- Output timing: all outputs are registered; busy = (state != IDLE).
- States: IDLE, ADD0, ADD1, ADD2, DONE.
- IDLE:
  - If newGame: clear as for reset, except the round-robin pointer is kept.
  - Else, if any scoreReq bit is set: pick the winner by round robin, starting from the requester after the last granted one. Latch addend = VALUE_winner, set scoreGrant[winner]=1 for the next cycle, go to ADD0.
- ADD0 (scoreGrant high this cycle only):
  - If saturated: discard the event, go to IDLE. No scoreChanged pulse.
  - Else sum = lowDigit + addend (5-bit). If sum>9: lowDigit=sum-10 and go to ADD1. Otherwise lowDigit=sum and go to DONE.
- ADD1: if midDigit==9, midDigit=0 and go to ADD2; else midDigit+1 and go to DONE.
- ADD2:
  - If highDigit==9: set all digits to 9, saturated=1, go to DONE.
  - Else highDigit+1, go to DONE.
- DONE: scoreChanged=1 for this cycle, flash counter loaded with FLASH_FRAMES, go to IDLE.
- Latency, measured from the clk edge at which IDLE samples a request:
  - No carry: digits update 2 edges later, and scoreChanged is high during that DONE cycle.
  - Each carry stage adds 1 cycle, so 999-class events take at most 4 cycles.
- Requester handshake:
  - A requester must drop its scoreReq within 2 cycles of seeing its grant.
  - Requests arriving while busy are held by the requester and are not lost.
  - Only one event is accepted per IDLE visit.
- newGame has priority in every state: synchronous clear, aborts any in-flight add, no grant is issued that cycle, flash counter cleared, state IDLE.
- Flash counter decrements on startOfFrame while non-zero; a load in DONE wins over a simultaneous decrement.
- Digits never leave the range 0..9; no intermediate non-BCD value is ever visible.
- reset asserted mid-add: the add is aborted, all outputs return to reset values on the next edge.

Test Plan:
- From reset, pulse scoreReq[0] until grant -> scoreGrant=3'b001 one cycle; digits 0/0/1 two edges after sampling; scoreChanged pulse; scoreFlash high for exactly 30 startOfFrame pulses.
- Score 007, scoreReq[1] -> 012 via ADD0->ADD1->DONE; busy high 3 cycles.
- Score 099, scoreReq[0] -> 100 with full carry chain; scoreChanged 4 cycles after sampling.
- Score 995, scoreReq[2] -> 999 and saturated=1. A further request is still granted, but digits stay 999 and there is no scoreChanged.
- All three scoreReq held continuously, each dropped on its grant -> grants 001, 010, 100 in order. Repeat with last grant=1 -> order 100, 001, 010.
- Score 099, scoreReq[0] then newGame asserted during ADD1 -> 000 next edge, state IDLE, no scoreChanged. Separately, reset asserted in ADD2 -> all reset values.

Source files
------------

// File: rtl/score_if.sv
// Score-keeper bundle: requester handshake, frame/game controls and the
// registered score/status outputs that feed the digit drawers.
interface score_if;
  logic       startOfFrame;
  logic       newGame;
  logic [2:0] scoreReq;
  logic [2:0] scoreGrant;
  logic [3:0] lowDigit;
  logic [3:0] midDigit;
  logic [3:0] highDigit;
  logic       busy;
  logic       scoreChanged;
  logic       saturated;
  logic       scoreFlash;

  modport master (
    output startOfFrame, newGame, scoreReq,
    input  scoreGrant, lowDigit, midDigit, highDigit,
    input  busy, scoreChanged, saturated, scoreFlash
  );

  modport slave (
    input  startOfFrame, newGame, scoreReq,
    output scoreGrant, lowDigit, midDigit, highDigit,
    output busy, scoreChanged, saturated, scoreFlash
  );
endinterface

// File: rtl/score_keeper.sv
// 3-digit BCD score register with round-robin event arbitration, a
// digit-serial carry FSM, saturation at 999 and a frame-counted flash.
module score_keeper #(
  parameter logic [3:0] VALUE0       = 4'd1,
  parameter logic [3:0] VALUE1       = 4'd5,
  parameter logic [3:0] VALUE2       = 4'd9,
  parameter logic [7:0] FLASH_FRAMES = 8'd30
) (
  input logic   clk,
  input logic   reset,
  score_if.slave sif
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADD0 = 3'd1;
  localparam logic [2:0] ADD1 = 3'd2;
  localparam logic [2:0] ADD2 = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0] state;
  logic [1:0] rr_ptr;
  logic [3:0] addend;
  logic [7:0] flash_cnt;
  logic [3:0] low;
  logic [3:0] mid;
  logic [3:0] high;
  logic [2:0] grant;
  logic       changed;
  logic       sat;

  logic [2:0] win;
  logic [4:0] low_sum;
  logic [4:0] mid_inc;
  logic [4:0] high_inc;

  // Returns {carry, digit}; digit is always a legal BCD value.
  function automatic logic [4:0] bcd_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
    return {1'b0, s[3:0]};
  endfunction

  function automatic logic [2:0] pick3(input logic [2:0] req, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] c);
    if (req[a]) return 3'b001 << a;
    if (req[b]) return 3'b001 << b;
    if (req[c]) return 3'b001 << c;
    return 3'b000;
  endfunction

  // rr_ptr names the requester that gets first look on the next IDLE visit.
  always_comb begin
    win = 3'b000;
    case (rr_ptr)
      2'd1:    win = pick3(sif.scoreReq, 2'd1, 2'd2, 2'd0);
      2'd2:    win = pick3(sif.scoreReq, 2'd2, 2'd0, 2'd1);
      default: win = pick3(sif.scoreReq, 2'd0, 2'd1, 2'd2);
    endcase
  end

  assign low_sum  = bcd_add(low, addend);
  assign mid_inc  = bcd_add(mid, 4'd1);
  assign high_inc = bcd_add(high, 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= 2'd0;
      addend    <= 4'd0;
      flash_cnt <= 8'd0;
      low       <= 4'd0;
      mid       <= 4'd0;
      high      <= 4'd0;
      grant     <= 3'b000;
      changed   <= 1'b0;
      sat       <= 1'b0;
    end else if (sif.newGame) begin
      state     <= IDLE;
      addend    <= 4'd0;
      flash_cnt <= 8'd0;
      low       <= 4'd0;
      mid       <= 4'd0;
      high      <= 4'd0;
      grant     <= 3'b000;
      changed   <= 1'b0;
      sat       <= 1'b0;
    end else begin
      grant   <= 3'b000;
      changed <= 1'b0;

      if (state == DONE)
        flash_cnt <= FLASH_FRAMES;
      else if (sif.startOfFrame && flash_cnt != 8'd0)
        flash_cnt <= flash_cnt - 8'd1;

      case (state)
        IDLE: begin
          if (win != 3'b000) begin
            grant <= win;
            state <= ADD0;
            if (win[0]) begin
              addend <= VALUE0;
              rr_ptr <= 2'd1;
            end else if (win[1]) begin
              addend <= VALUE1;
              rr_ptr <= 2'd2;
            end else begin
              addend <= VALUE2;
              rr_ptr <= 2'd0;
            end
          end
        end
        ADD0: begin
          if (sat) begin
            state <= IDLE;
          end else begin
            low <= low_sum[3:0];
            if (low_sum[4]) begin
              state <= ADD1;
            end else begin
              state   <= DONE;
              changed <= 1'b1;
              // Landing exactly on 999 without overflow still saturates.
              if (low_sum[3:0] == 4'd9 && mid == 4'd9 && high == 4'd9) sat <= 1'b1;
            end
          end
        end
        ADD1: begin
          mid <= mid_inc[3:0];
          if (mid_inc[4]) begin
            state <= ADD2;
          end else begin
            state   <= DONE;
            changed <= 1'b1;
          end
        end
        ADD2: begin
          state   <= DONE;
          changed <= 1'b1;
          if (high_inc[4]) begin
            low  <= 4'd9;
            mid  <= 4'd9;
            high <= 4'd9;
            sat  <= 1'b1;
          end else begin
            high <= high_inc[3:0];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign sif.scoreGrant   = grant;
  assign sif.lowDigit     = low;
  assign sif.midDigit     = mid;
  assign sif.highDigit    = high;
  assign sif.busy         = (state != IDLE);
  assign sif.scoreChanged = changed;
  assign sif.saturated    = sat;
  assign sif.scoreFlash   = (flash_cnt != 8'd0);

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: transaction-level score model plus directed
// scenarios and a randomized request/newGame/reset phase.
module tb_score_keeper;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  score_if sif();
  score_keeper dut (.clk(clk), .reset(reset), .sif(sif));

  int total = 0;
  int bad   = 0;

  localparam int FLASH = 30;

  // Model state: score as an integer, busy-cycle budget of the event in flight.
  int       m_score, m_pend, m_rem, m_flash, m_ptr, m_fnext;
  bit       m_sat, m_commit, m_chg;
  logic [2:0] m_grant;
  int       m_w, m_v, m_lo, m_mi;
  bit       m_c1, m_c2;

  function automatic int val(input int i);
    return (i == 0) ? 1 : (i == 1) ? 5 : 9;
  endfunction

  function automatic int digits();
    return int'(sif.highDigit) * 100 + int'(sif.midDigit) * 10 + int'(sif.lowDigit);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model, evaluated on the same edges as the DUT.
  initial begin
    m_score = 0; m_pend = 0; m_rem = 0; m_flash = 0; m_ptr = 0;
    m_sat = 0; m_commit = 0; m_chg = 0; m_grant = 3'b000;
    forever begin
      @(posedge clk);
      if (reset || sif.newGame) begin
        m_score = 0; m_rem = 0; m_flash = 0; m_sat = 0;
        m_commit = 0; m_chg = 0; m_grant = 3'b000;
        if (reset) m_ptr = 0;
      end else begin
        m_fnext = m_flash;
        if (m_rem == 1 && m_commit) m_fnext = FLASH;
        else if (sif.startOfFrame && m_flash > 0) m_fnext = m_flash - 1;
        m_chg = 0;
        m_grant = 3'b000;
        if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 1 && m_commit) begin
            m_score = m_pend;
            m_sat = (m_pend == 999);
            m_chg = 1;
          end
          if (m_rem == 0) m_commit = 0;
        end else if (sif.scoreReq != 3'b000) begin
          m_w = -1;
          for (int i = 0; i < 3; i++)
            if (m_w < 0 && sif.scoreReq[(m_ptr + i) % 3]) m_w = (m_ptr + i) % 3;
          m_grant = 3'b001 << m_w;
          m_ptr = (m_w + 1) % 3;
          if (m_sat) begin
            m_rem = 1;
            m_commit = 0;
          end else begin
            m_v  = val(m_w);
            m_lo = m_score % 10;
            m_mi = (m_score / 10) % 10;
            m_c1 = (m_lo + m_v) > 9;
            m_c2 = m_c1 && (m_mi == 9);
            m_rem = 2 + int'(m_c1) + int'(m_c2);
            m_commit = 1;
            m_pend = (m_score + m_v > 999) ? 999 : m_score + m_v;
          end
        end
        m_flash = m_fnext;
      end
    end
  end

  // Compare process, away from the active edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("grant", int'(sif.scoreGrant), int'(m_grant));
      chk("changed", int'(sif.scoreChanged), int'(m_chg));
      chk("busy", int'(sif.busy), int'(m_rem > 0));
      chk("saturated", int'(sif.saturated), int'(m_sat));
      chk("flash", int'(sif.scoreFlash), int'(m_flash > 0));
      chk("bcd_range", int'(sif.lowDigit <= 4'd9 && sif.midDigit <= 4'd9 && sif.highDigit <= 4'd9), 1);
      if (m_rem <= 1) chk("score", digits(), m_score);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    sif.startOfFrame = ($urandom_range(0, 3) == 0);
  endtask

  task automatic request(input int idx);
    bit got;
    got = 0;
    sif.scoreReq[idx] = 1'b1;
    for (int n = 0; n < 60 && !got; n++) begin
      step();
      if (sif.scoreGrant[idx]) got = 1;
    end
    sif.scoreReq[idx] = 1'b0;
    if (!got) chk("grant_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int n = 0; n < 30 && !done; n++) begin
      if (!sif.busy) done = 1;
      else step();
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  task automatic add_event(input int idx);
    request(idx);
    wait_idle();
  endtask

  task automatic new_game();
    sif.newGame = 1'b1;
    step();
    sif.newGame = 1'b0;
  endtask

  task automatic build(input int n9, input int n5);
    new_game();
    for (int i = 0; i < n9; i++) add_event(2);
    for (int i = 0; i < n5; i++) add_event(1);
  endtask

  task automatic rr_round(input string tag, input logic [2:0] e0, input logic [2:0] e1,
                          input logic [2:0] e2);
    logic [2:0] exp [3];
    int k;
    exp[0] = e0; exp[1] = e1; exp[2] = e2;
    k = 0;
    sif.scoreReq = 3'b111;
    for (int n = 0; n < 100 && k < 3; n++) begin
      step();
      if (sif.scoreGrant != 3'b000) begin
        chk(tag, int'(sif.scoreGrant), int'(exp[k]));
        sif.scoreReq = sif.scoreReq & ~sif.scoreGrant;
        k++;
      end
    end
    if (k < 3) chk({tag, "_timeout"}, k, 3);
    sif.scoreReq = 3'b000;
    wait_idle();
  endtask

  int n;

  initial begin
    reset = 1'b1;
    sif.newGame = 1'b0;
    sif.scoreReq = 3'b000;
    sif.startOfFrame = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    chk("reset_digits", digits(), 0);
    chk("reset_grant", int'(sif.scoreGrant), 0);
    chk("reset_busy", int'(sif.busy), 0);
    chk("reset_flash", int'(sif.scoreFlash), 0);

    // First event: +1, flash lasts exactly FLASH frames.
    request(0);
    chk("t1_grant", int'(sif.scoreGrant), 1);
    step();
    chk("t1_digits", digits(), 1);
    chk("t1_changed", int'(sif.scoreChanged), 1);
    step();
    chk("t1_flash_on", int'(sif.scoreFlash), 1);
    n = 0;
    for (int c = 0; c < 2000 && sif.scoreFlash; c++) begin
      if (sif.startOfFrame) n++;
      step();
    end
    chk("t1_flash_frames", n, 30);

    // 007 + 5 -> 012, one carry, busy three cycles.
    add_event(1);
    add_event(0);
    chk("t2_pre", digits(), 7);
    request(1);
    n = 0;
    for (int c = 0; c < 10 && sif.busy; c++) begin
      n++;
      step();
    end
    chk("t2_busy_cycles", n, 3);
    chk("t2_digits", digits(), 12);

    // 099 + 1 -> 100, full carry chain.
    build(11, 0);
    chk("t3_pre", digits(), 99);
    request(0);
    n = 1;
    for (int c = 0; c < 10 && !sif.scoreChanged; c++) begin
      step();
      n++;
    end
    chk("t3_changed_cycle", n, 4);
    chk("t3_digits", digits(), 100);
    wait_idle();

    // newGame during ADD1 aborts the add.
    build(11, 0);
    request(0);
    step();
    sif.newGame = 1'b1;
    step();
    sif.newGame = 1'b0;
    chk("t5_digits", digits(), 0);
    chk("t5_busy", int'(sif.busy), 0);
    chk("t5_changed", int'(sif.scoreChanged), 0);

    // reset during ADD2.
    build(11, 0);
    request(0);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_digits", digits(), 0);
    chk("t6_busy", int'(sif.busy), 0);
    chk("t6_flash", int'(sif.scoreFlash), 0);

    // Round robin from reset pointer, then after a grant to requester 1.
    rr_round("rr_a", 3'b001, 3'b010, 3'b100);
    add_event(1);
    rr_round("rr_b", 3'b100, 3'b001, 3'b010);

    // Saturation: 995 + 9 -> 999, further events granted but discarded.
    build(110, 1);
    chk("t4_pre", digits(), 995);
    add_event(2);
    chk("t4_digits", digits(), 999);
    chk("t4_sat", int'(sif.saturated), 1);
    request(0);
    chk("t4_grant", int'(sif.scoreGrant), 1);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (sif.scoreChanged) n++;
    end
    chk("t4_no_change", n, 0);
    chk("t4_hold", digits(), 999);

    // Randomized phase.
    new_game();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (sif.scoreReq[i] && sif.scoreGrant[i]) sif.scoreReq[i] = 1'b0;
        else if (!sif.scoreReq[i] && $urandom_range(0, 7) == 0) sif.scoreReq[i] = 1'b1;
      end
      sif.newGame = ($urandom_range(0, 199) == 0);
      reset = ($urandom_range(0, 599) == 0);
      step();
    end
    sif.scoreReq = 3'b000;
    sif.newGame = 1'b0;
    reset = 1'b0;
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
